// File: rtl/cntr_2_pkg.sv
// Shared definitions for the cntr_2 modulo-N up-counter: default width and
// the wrapped-increment helper used by the next-count logic.
package cntr_2_pkg;

    localparam int CNTR_2_DEF_WIDTH = 2;

    // Wrapped increment: returns 0 when cur has reached max, otherwise cur+1.
    function automatic logic [31:0] cntr_2_next(input logic [31:0] cur, input logic [31:0] max);
        logic [31:0] w_next;
        if (cur == max) begin
            w_next = '0;
        end else begin
            w_next = cur + 32'd1;
        end
        return w_next;
    endfunction

endpackage

// File: rtl/cntr_2.sv
// Free-running, clock-enabled modulo-MODULUS up-counter with async active-low reset.
// Define CNTR_2_TC_EN to add the combinational terminal-count output tc.
module cntr_2
    import cntr_2_pkg::*;
#(
    parameter int     WIDTH   = CNTR_2_DEF_WIDTH,
    parameter longint MODULUS = longint'(1) << WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    output logic [WIDTH-1:0] out
`ifdef CNTR_2_TC_EN
    ,
    output logic             tc
`endif
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("cntr_2: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("cntr_2: MODULUS must be in 2..2**WIDTH");
    end

    // Compare against the last legal value so non-power-of-2 moduli wrap early.
    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out <= '0;
        end else if (ce) begin
            r_out <= WIDTH'(cntr_2_next(32'(r_out), 32'(L_MAX)));
        end
    end

    assign out = r_out;

`ifdef CNTR_2_TC_EN
    // Out is 0 during reset and L_MAX >= 1, so tc is naturally low in reset.
    assign tc = ce & (r_out == L_MAX);
`endif

endmodule

// File: tb/tb_cntr_2.sv
// Directed self-checking bench for cntr_2: default 2-bit, MODULUS=3 and WIDTH=4 instances.
// Terminal-count checks are active when CNTR_2_TC_EN is defined.
module tb_cntr_2;

    logic       clk;
    logic       rst_a, ce_a;
    logic       rst_m3, ce_m3;
    logic       rst_w4, ce_w4;
    logic [1:0] out_a;
    logic [1:0] out_m3;
    logic [3:0] out_w4;
`ifdef CNTR_2_TC_EN
    logic       tc_a, tc_m3, tc_w4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cntr_2 u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .ce  (ce_a),
        .out (out_a)
`ifdef CNTR_2_TC_EN
        ,
        .tc  (tc_a)
`endif
    );

    cntr_2 #(.WIDTH(2), .MODULUS(3)) u_dut_m3 (
        .clk (clk),
        .rst (rst_m3),
        .ce  (ce_m3),
        .out (out_m3)
`ifdef CNTR_2_TC_EN
        ,
        .tc  (tc_m3)
`endif
    );

    cntr_2 #(.WIDTH(4)) u_dut_w4 (
        .clk (clk),
        .rst (rst_w4),
        .ce  (ce_w4),
        .out (out_w4)
`ifdef CNTR_2_TC_EN
        ,
        .tc  (tc_w4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_checks++;
        if (obs !== exp_val) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_val);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  exp2 [6];
        logic [1:0]  exp3 [4];
        logic [3:0]  pat;
        logic [3:0]  model;

        exp2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        exp3 = '{2'd1, 2'd2, 2'd0, 2'd1};
        pat  = 4'b1011;
        model = 4'd0;

        rst_a  = 1'b0; ce_a  = 1'b1;
        rst_m3 = 1'b0; ce_m3 = 1'b1;
        rst_w4 = 1'b0; ce_w4 = 1'b0;

        // 1: reset held with ce=1
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("rst_out", 32'(out_a), 32'd0);
`ifdef CNTR_2_TC_EN
            check_val("rst_tc", 32'(tc_a), 32'd0);
`endif
        end

        // 2: free count with wrap
        rst_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val($sformatf("cnt_%0d", i), 32'(out_a), 32'(exp2[i]));
`ifdef CNTR_2_TC_EN
            check_val($sformatf("cnt_tc_%0d", i), 32'(tc_a), (exp2[i] == 2'd3) ? 32'd1 : 32'd0);
`endif
        end

        // 3: hold with ce=0, then one enabled edge
        ce_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("hold_%0d", i), 32'(out_a), 32'd2);
`ifdef CNTR_2_TC_EN
            check_val($sformatf("hold_tc_%0d", i), 32'(tc_a), 32'd0);
`endif
        end
        ce_a = 1'b1;
        tick();
        check_val("resume", 32'(out_a), 32'd3);
`ifdef CNTR_2_TC_EN
        check_val("resume_tc", 32'(tc_a), 32'd1);
`endif

        // 4: asynchronous reset between edges
        #2;
        rst_a = 1'b0;
        #1;
        check_val("async_rst", 32'(out_a), 32'd0);
`ifdef CNTR_2_TC_EN
        check_val("async_rst_tc", 32'(tc_a), 32'd0);
`endif
        @(negedge clk);
        check_val("async_rst_hold", 32'(out_a), 32'd0);
        rst_a = 1'b1;
        tick();
        check_val("post_rst_1", 32'(out_a), 32'd1);
        tick();
        check_val("post_rst_2", 32'(out_a), 32'd2);

        // 5: MODULUS=3 sequence
        check_val("m3_init", 32'(out_m3), 32'd0);
        rst_m3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("m3_%0d", i), 32'(out_m3), 32'(exp3[i]));
`ifdef CNTR_2_TC_EN
            check_val($sformatf("m3_tc_%0d", i), 32'(tc_m3), (exp3[i] == 2'd2) ? 32'd1 : 32'd0);
`endif
        end

        // 6: WIDTH=4 with gated ce pattern against a reference model
        rst_w4 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ce_w4 = pat[3 - (i % 4)];
            tick();
            if (ce_w4) model = (model == 4'd15) ? 4'd0 : model + 4'd1;
            check_val($sformatf("w4_%0d", i), 32'(out_w4), 32'(model));
        end
        check_val("w4_final", 32'(out_w4), 32'd12);
`ifdef CNTR_2_TC_EN
        check_val("w4_tc", 32'(tc_w4), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
